// File: rtl/regfile_mp_pkg.sv
// Shared helpers and default types for the multi-port register file.
package regfile_pkg;

  function automatic int rf_aw(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  typedef logic [rf_aw(RF_NREGS)-1:0] rf_addr_t;
  typedef logic [RF_XLEN-1:0]         rf_data_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback side bus of the register file: read ports, write ports, issue, scoreboard.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
) ();
  import regfile_pkg::*;
  localparam int AW = rf_aw(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic [NREGS-1:0]    busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending flags: issue sets, writeback clears, set wins on a same-cycle collision.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = rf_aw(NREGS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic [NREGS-1:0]  wr_hit,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:0] iss_set;

  always_comb begin
    wr_hit = '0;
    for (int r = 0; r < NREGS; r++) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(r)) wr_hit[r] = 1'b1;
      end
    end
    // r0 is never written when hardwired, so it must never look like a writeback
    if (ZERO_REG != 0) wr_hit[0] = 1'b0;
  end

  always_comb begin
    iss_set = '0;
    if (iss_valid && !(ZERO_REG != 0 && iss_rd == '0)) iss_set[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy <= '0;
    else       busy <= (busy & ~wr_hit) | iss_set;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: storage, write-priority decode, combinational reads with bypass.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rstn,
  regfile_mp_if.slave bus
);

  localparam int AW = rf_aw(NREGS);

  logic [XLEN-1:0]  regs   [NREGS];
  logic [XLEN-1:0]  wr_sel [NREGS];
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] busy;

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .iss_valid (bus.iss_valid),
    .iss_rd    (bus.iss_rd),
    .wr_hit    (wr_hit),
    .busy      (busy)
  );

  // Ascending scan so the youngest (highest-index) matching port overrides older ones
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      wr_sel[r] = '0;
      for (int j = 0; j < NWR; j++) begin
        if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] == AW'(r))
          wr_sel[r] = bus.wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wr_hit[r]) regs[r] <= wr_sel[r];
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rv;

    assign ra = bus.rd_addr[i*AW +: AW];

    always_comb begin
      rv = regs[ra];
      if (BYPASS != 0 && wr_hit[ra]) rv = wr_sel[ra];
      if ((ZERO_REG != 0 && ra == '0) || !rstn) rv = '0;
    end

    assign bus.rd_data[i*XLEN +: XLEN] = rv;
    // A same-cycle writeback that is forwarded already resolves the hazard
    assign bus.rd_busy[i] = rstn && busy[ra] && !(BYPASS != 0 && wr_hit[ra]);
  end

  assign bus.busy_vec = busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Drives a bypassing and a non-bypassing register file with identical stimulus and checks both.
module tb_regfile_mp;
  localparam int XL  = 32;
  localparam int NR  = 64;
  localparam int AW  = 6;
  localparam int NRD = 3;
  localparam int NWR = 2;

  logic clk = 1'b0;
  logic rstn;
  logic [NRD*AW-1:0] rd_addr;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*XL-1:0] wr_data;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd;
  bit                chk_en = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [XL-1:0] mem [NR];
  bit            bsy [NR];

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XL), .NREGS(NR), .NRD(NRD), .NWR(NWR)) b1 ();
  regfile_mp_if #(.XLEN(XL), .NREGS(NR), .NRD(NRD), .NWR(NWR)) b0 ();

  assign b1.rd_addr = rd_addr;   assign b0.rd_addr = rd_addr;
  assign b1.wr_en   = wr_en;     assign b0.wr_en   = wr_en;
  assign b1.wr_addr = wr_addr;   assign b0.wr_addr = wr_addr;
  assign b1.wr_data = wr_data;   assign b0.wr_data = wr_data;
  assign b1.iss_valid = iss_valid; assign b0.iss_valid = iss_valid;
  assign b1.iss_rd  = iss_rd;    assign b0.iss_rd  = iss_rd;

  regfile_mp #(.XLEN(XL), .NREGS(NR), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG(1))
    u_bp1 (.clk(clk), .rstn(rstn), .bus(b1));
  regfile_mp #(.XLEN(XL), .NREGS(NR), .NRD(NRD), .NWR(NWR), .BYPASS(0), .ZERO_REG(1))
    u_bp0 (.clk(clk), .rstn(rstn), .bus(b0));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural state updated once per accepted edge
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NR; r++) begin
        mem[r] <= '0;
        bsy[r] <= 1'b0;
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != 0) begin
          mem[wr_addr[j*AW +: AW]] <= wr_data[j*XL +: XL];
          bsy[wr_addr[j*AW +: AW]] <= 1'b0;
        end
      end
      if (iss_valid && iss_rd != 0) bsy[iss_rd] <= 1'b1;
    end
  end

  function automatic bit m_hit(input int a);
    for (int j = 0; j < NWR; j++)
      if (a != 0 && wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [XL-1:0] m_data(input bit bp, input int a);
    if (!rstn || a == 0) return '0;
    if (bp)
      for (int j = NWR - 1; j >= 0; j--)
        if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) return wr_data[j*XL +: XL];
    return mem[a];
  endfunction

  function automatic bit m_rbusy(input bit bp, input int a);
    if (!rstn || a == 0 || !bsy[a]) return 1'b0;
    return !(bp && m_hit(a));
  endfunction

  function automatic logic [NR-1:0] m_bvec();
    logic [NR-1:0] v;
    for (int r = 0; r < NR; r++) v[r] = bsy[r];
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NRD; i++) begin
        int a;
        a = int'(rd_addr[i*AW +: AW]);
        chk("rd_data_bp1", b1.rd_data[i*XL +: XL], m_data(1'b1, a));
        chk("rd_data_bp0", b0.rd_data[i*XL +: XL], m_data(1'b0, a));
        chk("rd_busy_bp1", b1.rd_busy[i], m_rbusy(1'b1, a));
        chk("rd_busy_bp0", b0.rd_busy[i], m_rbusy(1'b0, a));
      end
      chk("busy_vec_bp1", b1.busy_vec, m_bvec());
      chk("busy_vec_bp0", b0.busy_vec, m_bvec());
    end
  end

  task automatic idle();
    wr_en = '0;
    iss_valid = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_wr(input int j, input int a, input logic [XL-1:0] d);
    wr_en[j] = 1'b1;
    wr_addr[j*AW +: AW] = AW'(a);
    wr_data[j*XL +: XL] = d;
  endtask

  task automatic set_rd(input int i, input int a);
    rd_addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic issue(input int a);
    iss_valid = 1'b1;
    iss_rd = AW'(a);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; iss_rd = '0;
    idle();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy_vec", b1.busy_vec, 64'h0);
    chk("reset_rd_data", b1.rd_data[XL-1:0], 32'h0);
    @(posedge clk); #2 rstn = 1'b1;

    // same-address dual write: port 1 wins
    nxt();
    set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); set_rd(0, 7);
    @(negedge clk);
    chk("t2_bypass_same_cycle", b1.rd_data[XL-1:0], 32'h22);
    chk("t2_nobypass_same_cycle", b0.rd_data[XL-1:0], 32'h0);
    nxt();
    @(negedge clk);
    chk("t2_stored", b0.rd_data[XL-1:0], 32'h22);

    // r0 hardwired
    nxt();
    set_wr(1, 0, 32'hFFFF_FFFF); issue(0); set_rd(0, 0);
    nxt();
    @(negedge clk);
    chk("t3_r0_read", b1.rd_data[XL-1:0], 32'h0);
    chk("t3_r0_busy", b1.busy_vec[0], 1'b0);

    // scoreboard hazard and resolution
    nxt();
    issue(3); set_rd(0, 3);
    @(negedge clk);
    chk("t4_issue_no_same_cycle_busy", b1.rd_busy[0], 1'b0);
    nxt();
    @(negedge clk);
    chk("t4_busy_after_issue_bp1", b1.rd_busy[0], 1'b1);
    chk("t4_busy_after_issue_bp0", b0.rd_busy[0], 1'b1);
    nxt();
    set_wr(0, 3, 32'h5);
    @(negedge clk);
    chk("t4_wb_busy_bp1", b1.rd_busy[0], 1'b0);
    chk("t4_wb_data_bp1", b1.rd_data[XL-1:0], 32'h5);
    chk("t4_wb_busy_bp0", b0.rd_busy[0], 1'b1);
    nxt();
    @(negedge clk);
    chk("t4_after_wb_busy_bp0", b0.rd_busy[0], 1'b0);
    chk("t4_after_wb_data_bp0", b0.rd_data[XL-1:0], 32'h5);

    // issue and writeback of the same register: set wins
    nxt();
    issue(9); set_wr(1, 9, 32'hABC); set_rd(1, 9);
    nxt();
    @(negedge clk);
    chk("t5_busy9", b0.busy_vec[9], 1'b1);
    chk("t5_data9", b0.rd_data[2*XL-1:XL], 32'hABC);

    // asynchronous reset mid-cycle
    nxt();
    set_wr(0, 5, 32'hDEAD); issue(12); set_rd(0, 5);
    nxt();
    @(negedge clk);
    chk("t1_pre_reset_data", b0.rd_data[XL-1:0], 32'hDEAD);
    chk("t1_pre_reset_busy12", b1.busy_vec[12], 1'b1);
    @(posedge clk); #3 rstn = 1'b0;
    #1;
    chk("t1_rd_in_reset", b1.rd_data[XL-1:0], 32'h0);
    chk("t1_busy_vec_in_reset", b1.busy_vec, 64'h0);
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("t1_after_reset_data", b0.rd_data[XL-1:0], 32'h0);

    // sweep every register through every write port, read on all ports
    for (int r = 0; r < NR; r++) begin
      for (int j = 0; j < NWR; j++) begin
        nxt();
        set_wr(j, r, $urandom);
        if ($urandom_range(0, 1) == 1) issue($urandom_range(0, NR - 1));
        for (int i = 0; i < NRD; i++) set_rd(i, r);
      end
    end

    // random traffic with collisions and occasional mid-cycle reset
    repeat (3000) begin
      bit narrow;
      nxt();
      if (!rstn) rstn = 1'b1;
      narrow = ($urandom_range(0, 1) == 1);
      for (int j = 0; j < NWR; j++) begin
        wr_en[j] = ($urandom_range(0, 2) != 0);
        wr_addr[j*AW +: AW] = AW'(narrow ? $urandom_range(0, 7) : $urandom_range(0, NR - 1));
        wr_data[j*XL +: XL] = $urandom;
      end
      iss_valid = ($urandom_range(0, 1) == 1);
      iss_rd = AW'(narrow ? $urandom_range(0, 7) : $urandom_range(0, NR - 1));
      for (int i = 0; i < NRD; i++)
        set_rd(i, narrow ? $urandom_range(0, 7) : $urandom_range(0, NR - 1));
      if ($urandom_range(0, 299) == 0) begin
        #2 rstn = 1'b0;
      end
    end

    nxt();
    rstn = 1'b1;
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
